// File: rtl/bp_me_cache_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_cache_dma_arbiter
// Purpose  : Shares one DRAM DMA channel among the banks of an L2 cache slice.
// Revision : 1.0  initial release
// ============================================================================
module bp_me_cache_dma_arbiter #(
   parameter int num_banks_p       = 2,
   parameter int dma_pkt_width_p   = 41,
   parameter int fill_width_p      = 64,
   parameter int block_width_p     = 512,
   parameter int max_outstanding_p = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,

   input  logic [num_banks_p*dma_pkt_width_p-1:0] dma_pkt_i,
   input  logic [num_banks_p-1:0]                 dma_pkt_v_i,
   output logic [num_banks_p-1:0]                 dma_pkt_ready_and_o,

   output logic [num_banks_p*fill_width_p-1:0]    dma_data_o,
   output logic [num_banks_p-1:0]                 dma_data_v_o,
   input  logic [num_banks_p-1:0]                 dma_data_ready_and_i,

   input  logic [num_banks_p*fill_width_p-1:0]    dma_data_i,
   input  logic [num_banks_p-1:0]                 dma_data_v_i,
   output logic [num_banks_p-1:0]                 dma_data_ready_and_o,

   output logic [dma_pkt_width_p-1:0]             mem_dma_pkt_o,
   output logic                                   mem_dma_pkt_v_o,
   input  logic                                   mem_dma_pkt_ready_and_i,

   input  logic [fill_width_p-1:0]                mem_dma_data_i,
   input  logic                                   mem_dma_data_v_i,
   output logic                                   mem_dma_data_ready_and_o,

   output logic [fill_width_p-1:0]                mem_dma_data_o,
   output logic                                   mem_dma_data_v_o,
   input  logic                                   mem_dma_data_ready_and_i
);

   localparam int beats_lp  = block_width_p / fill_width_p;
   localparam int id_w_lp   = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
   localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);
   localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

   typedef logic [id_w_lp-1:0] id_t;

   typedef enum logic [0:0] {
      st_arb  = 1'b0,
      st_hold = 1'b1
   } state_t;

   // Tracking slot 0 holds read bank ids, slot 1 holds write bank ids.
   logic [1:0]              fifo_push;
   logic [1:0]              fifo_pop;
   logic [1:0]              fifo_full;
   logic [1:0]              fifo_empty;
   logic [1:0]              beat_hs;
   logic [1:0][id_w_lp-1:0] fifo_head;
   id_t                     fifo_din;

   for (genvar f = 0; f < 2; f++) begin : g_track
      id_t                  mem [max_outstanding_p];
      logic [ptr_w_lp-1:0]  wr_ptr;
      logic [ptr_w_lp-1:0]  rd_ptr;
      logic [cnt_w_lp-1:0]  count;
      logic [beat_w_lp-1:0] beat_cnt;
      logic                 beat_last;

      assign fifo_full[f]  = (count == cnt_w_lp'(max_outstanding_p));
      assign fifo_empty[f] = (count == '0);
      assign fifo_head[f]  = mem[rd_ptr];
      assign beat_last     = (beat_cnt == beat_w_lp'(beats_lp - 1));
      assign fifo_pop[f]   = beat_hs[f] & beat_last;

      always_ff @(posedge clk_i) begin
         if (fifo_push[f]) begin
            mem[wr_ptr] <= fifo_din;
         end
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
         end else begin
            if (fifo_push[f]) begin
               wr_ptr <= (wr_ptr == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr + ptr_w_lp'(1);
            end
            if (fifo_pop[f]) begin
               rd_ptr <= (rd_ptr == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr + ptr_w_lp'(1);
            end
            count <= count + cnt_w_lp'(fifo_push[f]) - cnt_w_lp'(fifo_pop[f]);
            if (beat_hs[f]) begin
               beat_cnt <= beat_last ? '0 : beat_cnt + beat_w_lp'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Command arbitration
   // ------------------------------------------------------------------------
   logic [num_banks_p-1:0] pkt_is_write;
   logic [num_banks_p-1:0] eligible;
   id_t                    rr_ptr;
   id_t                    rr_ptr_next;
   id_t                    lock_id;
   id_t                    arb_id;
   id_t                    grant_id;
   logic                   arb_found;
   logic                   grant_v;
   logic                   grant_write;
   logic                   pkt_hs;
   state_t                 state;
   state_t                 state_next;

   always_comb begin
      pkt_is_write = '0;
      eligible     = '0;
      for (int i = 0; i < num_banks_p; i++) begin
         pkt_is_write[i] = dma_pkt_i[i*dma_pkt_width_p + dma_pkt_width_p - 1];
         eligible[i]     = dma_pkt_v_i[i] & ~(pkt_is_write[i] ? fifo_full[1] : fifo_full[0]);
      end
   end

   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      for (int k = 0; k < num_banks_p; k++) begin
         for (int i = 0; i < num_banks_p; i++) begin
            if (!arb_found && eligible[i] && (i == (int'(rr_ptr) + k) % num_banks_p)) begin
               arb_found = 1'b1;
               arb_id    = id_t'(i);
            end
         end
      end
   end

   // A stalled grant stays on its bank until the memory side accepts it.
   always_comb begin
      grant_id      = (state == st_hold) ? lock_id : arb_id;
      grant_v       = 1'b0;
      grant_write   = 1'b0;
      mem_dma_pkt_o = '0;
      for (int i = 0; i < num_banks_p; i++) begin
         if (grant_id == id_t'(i)) begin
            grant_v       = (state == st_hold) ? dma_pkt_v_i[i] : arb_found;
            grant_write   = pkt_is_write[i];
            mem_dma_pkt_o = dma_pkt_i[i*dma_pkt_width_p +: dma_pkt_width_p];
         end
      end
   end

   assign mem_dma_pkt_v_o = grant_v & ~reset_i;
   assign pkt_hs          = mem_dma_pkt_v_o & mem_dma_pkt_ready_and_i;
   assign fifo_push[0]    = pkt_hs & ~grant_write;
   assign fifo_push[1]    = pkt_hs & grant_write;
   assign fifo_din        = grant_id;
   assign rr_ptr_next     = (grant_id == id_t'(num_banks_p - 1)) ? '0 : grant_id + id_t'(1);

   always_comb begin
      dma_pkt_ready_and_o = '0;
      for (int i = 0; i < num_banks_p; i++) begin
         dma_pkt_ready_and_o[i] = pkt_hs & (grant_id == id_t'(i));
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         st_arb:  if (mem_dma_pkt_v_o && !mem_dma_pkt_ready_and_i) state_next = st_hold;
         st_hold: if (pkt_hs) state_next = st_arb;
         default: state_next = st_arb;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= st_arb;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else begin
         state   <= state_next;
         lock_id <= grant_id;
         if (pkt_hs) begin
            rr_ptr <= rr_ptr_next;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read return and writeback steering
   // ------------------------------------------------------------------------
   assign dma_data_o = {num_banks_p{mem_dma_data_i}};

   always_comb begin
      dma_data_v_o             = '0;
      dma_data_ready_and_o     = '0;
      mem_dma_data_ready_and_o = 1'b0;
      mem_dma_data_v_o         = 1'b0;
      mem_dma_data_o           = '0;
      for (int i = 0; i < num_banks_p; i++) begin
         if (!reset_i && !fifo_empty[0] && (fifo_head[0] == id_t'(i))) begin
            dma_data_v_o[i]          = mem_dma_data_v_i;
            mem_dma_data_ready_and_o = dma_data_ready_and_i[i];
         end
         if (fifo_head[1] == id_t'(i)) begin
            mem_dma_data_o = dma_data_i[i*fill_width_p +: fill_width_p];
            if (!reset_i && !fifo_empty[1]) begin
               mem_dma_data_v_o        = dma_data_v_i[i];
               dma_data_ready_and_o[i] = mem_dma_data_ready_and_i;
            end
         end
      end
   end

   assign beat_hs[0] = mem_dma_data_v_i & mem_dma_data_ready_and_o;
   assign beat_hs[1] = mem_dma_data_v_o & mem_dma_data_ready_and_i;

endmodule
`default_nettype wire
